// File: rtl/seq_divider_pkg.sv
// Shared opcodes and datapath width used by the multiplier, the divider and the controller.
package seq_divider_pkg;

  localparam int        WIDTH = 32;
  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] DIVU  = 6'd27;
  localparam logic [5:0] OUT   = 6'd63;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration: shift {rem,quo} left, subtract divisor if it fits.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       fits;

  // Keep the bit shifted out of rem so divisors above 2^(W-1) compare exactly.
  assign shifted = {rem, quo[W-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign fits    = (shifted >= {1'b0, divisor});

  assign rem_next = fits ? diff[W-1:0] : shifted[W-1:0];
  assign quo_next = {quo[W-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, one quotient bit per clock; result {remainder, quotient}
// is held in a result register and copied to dataOut only on the OUT opcode.
module seq_divider #(
  parameter int         WIDTH = seq_divider_pkg::WIDTH,
  parameter logic [5:0] DIVU  = seq_divider_pkg::DIVU,
  parameter logic [5:0] OUT   = seq_divider_pkg::OUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  input  logic [5:0]         Signal,
  output logic [2*WIDTH-1:0] dataOut,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic               start;
  logic               last_step;

  div_step #(.W(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (b_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  assign start     = (state == IDLE) && (Signal == DIVU);
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (dataB == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      dataOut     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // OUT reads the result register, so it never exposes an in-flight division.
      if (Signal == OUT) dataOut <= result_q;

      if (start) begin
        div_by_zero <= (dataB == '0);
        if (dataB == '0) begin
          result_q <= {dataA, {WIDTH{1'b1}}};
        end else begin
          b_q   <= dataB;
          rem_q <= '0;
          quo_q <= dataA;
          cnt_q <= '0;
        end
      end else if (state == RUN) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + 1'b1;
        if (last_step) result_q <= {rem_nx, quo_nx};
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_OUT  = 6'd63;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_divider dut (
    .clk         (clk),
    .reset       (reset),
    .dataA       (dataA),
    .dataB       (dataB),
    .Signal      (Signal),
    .dataOut     (dataOut),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_out;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = OP_DIVU;
    @(posedge clk);
  endtask

  // Returns the negedge index (1 = cycle after start edge) at which done was first seen.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      Signal = OP_NOP;
      dataA  = 32'hDEAD_BEEF;
      dataB  = 32'h0000_0003;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_out();
    @(negedge clk);
    Signal = OP_OUT;
    @(negedge clk);
    Signal = OP_NOP;
  endtask

  initial begin
    int  lat;
    bit  saw_done;

    vecs[0] = '{32'd100,        32'd7,          64'h00000002_0000000E, 1'b0, 33};
    vecs[1] = '{32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 1'b0, 33};
    vecs[2] = '{32'hFFFFFFFF,   32'h80000001,   64'h7FFFFFFE_00000001, 1'b0, 33};
    vecs[3] = '{32'd5,          32'd0,          64'h00000005_FFFFFFFF, 1'b1, 1};
    vecs[4] = '{32'd3,          32'd10,         64'h00000003_00000000, 1'b0, 33};
    vecs[5] = '{32'd1000000,    32'd1000,       64'h00000000_000003E8, 1'b0, 33};
    vecs[6] = '{32'h12345678,   32'h00000100,   64'h00000078_00123456, 1'b0, 33};
    vecs[7] = '{32'd0,          32'd5,          64'h00000000_00000000, 1'b0, 33};
    vecs[8] = '{32'd7,          32'd7,          64'h00000000_00000001, 1'b0, 33};

    reset  = 1'b1;
    dataA  = '0;
    dataB  = '0;
    Signal = OP_NOP;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_dataOut", dataOut, 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_dz", {63'h0, div_by_zero}, 64'h0);

    foreach (vecs[i]) begin
      start_div(vecs[i].a, vecs[i].b);
      wait_done(lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_busy_at_done", i), {63'h0, busy}, 64'h0);
      do_out();
      check($sformatf("v%0d_dataOut", i), dataOut, vecs[i].exp_out);
      check($sformatf("v%0d_dz", i), {63'h0, div_by_zero}, {63'h0, vecs[i].exp_dz});
      check($sformatf("v%0d_done_pulse", i), {63'h0, done}, 64'h0);
    end

    // Reset in the middle of a division: aborted, no done, result register cleared.
    start_div(32'd100, 32'd7);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      Signal = OP_NOP;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_dataOut", dataOut, 64'h0);
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {63'h0, saw_done}, 64'h0);
    do_out();
    check("abort_out", dataOut, 64'h0);

    // Establish a prior result, then check a second DIVU mid-run is ignored.
    start_div(32'd3, 32'd10);
    wait_done(lat);
    start_div(32'd100, 32'd7);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      Signal = OP_NOP;
      if (n == 5) begin
        Signal = OP_DIVU;
        dataA  = 32'd9;
        dataB  = 32'd3;
      end
      if (n == 10) Signal = OP_OUT;
      if (n == 11) begin
        check("mid_out_prior", dataOut, 64'h00000003_00000000);
        check("mid_busy", {63'h0, busy}, 64'h1);
      end
      if (done) begin
        lat = n;
        break;
      end
    end
    check("ignore_latency", 64'(lat), 64'd33);
    do_out();
    check("ignore_result", dataOut, 64'h00000002_0000000E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
